tcam_sram_wr_ctrl: RTL

TCAM_SRAM_WR_CTRL -- requirements
Module: tcam_sram_wr_ctrl

---
 rtl/tcam_ctrl_pkg.sv | 27 ++
 rtl/tcam_sram_wr_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/tcam_ctrl_pkg.sv
// Shared types and helpers for the TCAM column-write controller.
// Holds the FSM state encoding, the default geometry and the ternary match rule.
package tcam_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_WMASKS = 4;
  // Widest query the match helper handles; narrower operands are zero-extended.
  localparam int MATCH_WIDTH    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  // A row matches when every cared-for bit of the row address equals the key.
  // Deleting clears the entry bit unconditionally.
  function automatic logic match_bit(input logic                   del,
                                     input logic [MATCH_WIDTH-1:0] addr,
                                     input logic [MATCH_WIDTH-1:0] key,
                                     input logic [MATCH_WIDTH-1:0] care);
    return !del && (((addr ^ key) & care) == '0);
  endfunction

endpackage

// File: rtl/tcam_sram_wr_ctrl.sv
// Rewrites one TCAM entry (an SRAM bit column) by read-modify-write over every
// row address, so that a row holds a 1 exactly where the row address matches the key.
module tcam_sram_wr_ctrl
  import tcam_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WMASKS = DEF_NUM_WMASKS
) (
  input  logic                          clk0,
  input  logic                          rstb0,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_del,
  input  logic [$clog2(DATA_WIDTH)-1:0] req_entry,
  input  logic [ADDR_WIDTH-1:0]         req_key,
  input  logic [ADDR_WIDTH-1:0]         req_care,
  output logic                          busy,
  output logic                          done,
  output logic                          csb0,
  output logic                          web0,
  output logic [NUM_WMASKS-1:0]         wmask0,
  output logic [ADDR_WIDTH-1:0]         addr0,
  output logic [DATA_WIDTH-1:0]         din0,
  input  logic [DATA_WIDTH-1:0]         dout0
);

  localparam int EW = $clog2(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [EW-1:0]         entry_q;
  logic [ADDR_WIDTH-1:0] key_q;
  logic [ADDR_WIDTH-1:0] care_q;
  logic                  del_q;
  logic [DATA_WIDTH-1:0] bit_sel;
  logic                  match;

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk0 or negedge rstb0) begin
    if (!rstb0) begin
      state     <= IDLE;
      cnt       <= '0;
      entry_q   <= '0;
      key_q     <= '0;
      care_q    <= '0;
      del_q     <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      csb0      <= 1'b1;
      web0      <= 1'b1;
      wmask0    <= '0;
      addr0     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            entry_q   <= req_entry;
            key_q     <= req_key;
            care_q    <= req_care;
            del_q     <= req_del;
            cnt       <= '0;
            state     <= RD;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            csb0      <= 1'b0;
            web0      <= 1'b1;
            addr0     <= '0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD: begin
          state  <= WR;
          web0   <= 1'b0;
          wmask0 <= NUM_WMASKS'(1) << (entry_q >> 3);
        end
        WR: begin
          wmask0 <= '0;
          web0   <= 1'b1;
          if (cnt != LAST_ROW) begin
            cnt   <= cnt + ADDR_WIDTH'(1);
            addr0 <= cnt + ADDR_WIDTH'(1);
            state <= RD;
          end else begin
            // Counter is left at the last row; it is cleared on the next accept.
            state <= DONE;
            csb0  <= 1'b1;
            addr0 <= '0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write data must merge the word read back this cycle, so it is decoded, not registered.
  always_comb begin
    bit_sel = DATA_WIDTH'(1) << entry_q;
    match   = match_bit(del_q, MATCH_WIDTH'(cnt), MATCH_WIDTH'(key_q), MATCH_WIDTH'(care_q));
    din0    = '0;
    if (state == WR) din0 = (dout0 & ~bit_sel) | (match ? bit_sel : '0);
  end

endmodule
